// File: rtl/program_port_arbiter.sv
// program_port_arbiter: round-robin sharing of one combinational program-memory read port
// between a fetch (I) and a load/debug (D) requester, with one-cycle registered responses.
module program_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_IReq,
  input  logic [ADDR_WIDTH-1:0] i_IAddr,
  output logic                  o_IAck,
  output logic                  o_IValid,
  output logic [INST_WIDTH-1:0] o_IData,
  output logic                  o_IErr,
  input  logic                  i_DReq,
  input  logic [ADDR_WIDTH-1:0] i_DAddr,
  output logic                  o_DAck,
  output logic                  o_DValid,
  output logic [INST_WIDTH-1:0] o_DData,
  output logic                  o_DErr,
  output logic [ADDR_WIDTH-1:0] o_MemAddr,
  input  logic [INST_WIDTH-1:0] i_MemData
);
  typedef enum logic {PRIO_I, PRIO_D} prio_t;
  prio_t                 prio_q, prio_d;
  logic                  i_valid_q, i_valid_d, d_valid_q, d_valid_d;
  logic                  i_err_q, i_err_d, d_err_q, d_err_d;
  logic [INST_WIDTH-1:0] i_data_q, i_data_d, d_data_q, d_data_d;
  logic                  grant_i, grant_d, misaligned;
  logic [INST_WIDTH-1:0] word;
  // Acks are gated by reset so nothing is granted while the block is held in reset.
  always_comb begin
    grant_i    = i_Reset && i_IReq && (!i_DReq || prio_q == PRIO_I);
    grant_d    = i_Reset && i_DReq && (!i_IReq || prio_q == PRIO_D);
    o_MemAddr  = grant_i ? i_IAddr : grant_d ? i_DAddr : '0;
    misaligned = |o_MemAddr[1:0];
    word       = misaligned ? '0 : i_MemData;
    prio_d     = grant_i ? PRIO_D : grant_d ? PRIO_I : prio_q;
    i_valid_d  = grant_i;
    i_data_d   = grant_i ? word : i_data_q;
    i_err_d    = grant_i ? misaligned : i_err_q;
    d_valid_d  = grant_d;
    d_data_d   = grant_d ? word : d_data_q;
    d_err_d    = grant_d ? misaligned : d_err_q;
  end
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      prio_q    <= PRIO_I;
      i_valid_q <= 1'b0;
      i_data_q  <= '0;
      i_err_q   <= 1'b0;
      d_valid_q <= 1'b0;
      d_data_q  <= '0;
      d_err_q   <= 1'b0;
    end else begin
      prio_q    <= prio_d;
      i_valid_q <= i_valid_d;
      i_data_q  <= i_data_d;
      i_err_q   <= i_err_d;
      d_valid_q <= d_valid_d;
      d_data_q  <= d_data_d;
      d_err_q   <= d_err_d;
    end
  end
  assign o_IAck   = grant_i;
  assign o_DAck   = grant_d;
  assign o_IValid = i_valid_q;
  assign o_IData  = i_data_q;
  assign o_IErr   = i_err_q;
  assign o_DValid = d_valid_q;
  assign o_DData  = d_data_q;
  assign o_DErr   = d_err_q;
endmodule
